apb_reg_bank: RTL and testbench

- Parametrised APB3-style slave register bank. Successor to the existing single-width memory block.
- Adds byte write strobes, programmable wait states, PSLVERR-style error response and an explicit protocol state machine.
- Sits on the peripheral bus behind the bus bridge. Holds DEPTH words of DATA_WIDTH bits.

---
 rtl/apb_reg_bank.sv | 121 ++++++++++++
 tb/tb_apb_reg_bank.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/apb_reg_bank.sv
// APB3-style slave register bank: DEPTH x DATA_WIDTH registers, byte strobes, wait states, error response.
// Optional write lock through register DEPTH-1, enabled by defining APB_REG_BANK_LOCK_EN.
module apb_reg_bank #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH = 48,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter logic [DATA_WIDTH-1:0] RESET_VAL = '0,
    parameter int WAIT_STATES = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [ADDR_WIDTH-1:0]   addr,
    input  logic                    wr,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] strb,
    input  logic                    sel,
    input  logic                    enable,
    output logic                    ready,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic                    slverr
);
    localparam int NB = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH:0]   DEPTH_W   = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [3:0]            WS        = 4'(WAIT_STATES);

    typedef enum logic [1:0] {IDLE, WAIT, READY} state_t;

    state_t                  state, state_n;
    logic [3:0]              cnt, cnt_n;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic                    wr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [NB-1:0]           strb_q;
    logic                    err_q, err_d;
    logic                    latch, do_write;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];

`ifdef APB_REG_BANK_LOCK_EN
    // Lock only blocks writes below the lock register so the bank can always be unlocked.
    logic lock;
    assign lock  = mem[DEPTH-1][0];
    assign err_d = ({1'b0, addr} >= DEPTH_W) | (wr & lock & (addr != LAST_ADDR));
`else
    assign err_d = ({1'b0, addr} >= DEPTH_W);
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        latch    = 1'b0;
        do_write = 1'b0;
        case (state)
            IDLE: begin
                if (sel && !enable) begin
                    latch   = 1'b1;
                    cnt_n   = WS;
                    state_n = (WAIT_STATES > 0) ? WAIT : READY;
                end
            end
            WAIT: begin
                if (!sel) begin
                    state_n = IDLE;
                end else if (enable) begin
                    cnt_n = cnt - 4'd1;
                    if (cnt == 4'd1) state_n = READY;
                end
            end
            READY: begin
                if (!sel) begin
                    state_n = IDLE;
                end else if (enable) begin
                    state_n  = IDLE;
                    do_write = wr_q & ~err_q;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q  <= '0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
            strb_q  <= '0;
            err_q   <= 1'b0;
        end else if (latch) begin
            addr_q  <= addr;
            wr_q    <= wr;
            wdata_q <= wdata;
            strb_q  <= strb;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= RESET_VAL;
        end else if (do_write) begin
            for (int b = 0; b < NB; b++)
                if (strb_q[b]) mem[addr_q][8*b +: 8] <= wdata_q[8*b +: 8];
        end
    end

    // Outputs depend only on registered state and latched fields.
    assign ready  = (state == READY);
    assign slverr = ready & err_q;
    assign rdata  = (ready && !wr_q && !err_q) ? mem[addr_q] : '0;

endmodule

// File: tb/tb_apb_reg_bank.sv
// Directed bench for apb_reg_bank: one zero-wait instance (reset value A5A5A5A5) and one 3-wait instance.
module tb_apb_reg_bank;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [5:0]  addr = '0;
    logic        wr = 1'b0;
    logic [31:0] wdata = '0;
    logic [3:0]  strb = '0;
    logic        sel0 = 1'b0, sel3 = 1'b0, enable = 1'b0;
    logic        ready0, ready3, slverr0, slverr3;
    logic [31:0] rdata0, rdata3;

    int applied = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    apb_reg_bank #(.DATA_WIDTH(32), .DEPTH(48), .RESET_VAL(32'hA5A5A5A5), .WAIT_STATES(0)) dut0 (
        .clk(clk), .reset(reset), .addr(addr), .wr(wr), .wdata(wdata), .strb(strb),
        .sel(sel0), .enable(enable), .ready(ready0), .rdata(rdata0), .slverr(slverr0));

    apb_reg_bank #(.DATA_WIDTH(32), .DEPTH(48), .RESET_VAL(32'h0), .WAIT_STATES(3)) dut3 (
        .clk(clk), .reset(reset), .addr(addr), .wr(wr), .wdata(wdata), .strb(strb),
        .sel(sel3), .enable(enable), .ready(ready3), .rdata(rdata3), .slverr(slverr3));

    typedef struct {
        int          d;
        logic        w;
        logic [5:0]  a;
        logic [31:0] wd;
        logic [3:0]  s;
        logic [31:0] exp_rd;
        logic        exp_err;
        int          exp_wait;
    } vec_t;

    vec_t vt[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        applied++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic rdy(input int d);
        return (d == 0) ? ready0 : ready3;
    endfunction

    // Full transfer; bus fields are scrambled during the access phase to prove they were latched.
    task automatic xfer(input int d, input logic w, input logic [5:0] a, input logic [31:0] wd,
                        input logic [3:0] s, output logic [31:0] rd, output logic err,
                        output int nwait, output logic tmo);
        @(negedge clk);
        if (d == 0) sel0 = 1'b1; else sel3 = 1'b1;
        enable = 1'b0; wr = w; addr = a; wdata = wd; strb = s;
        @(negedge clk);
        enable = 1'b1; wr = ~w; addr = ~a; wdata = ~wd; strb = ~s;
        nwait = 0;
        while (!rdy(d) && nwait < 40) begin
            @(negedge clk);
            nwait++;
        end
        tmo = ~rdy(d);
        rd  = (d == 0) ? rdata0 : rdata3;
        err = (d == 0) ? slverr0 : slverr3;
        @(negedge clk);
        sel0 = 1'b0; sel3 = 1'b0; enable = 1'b0;
    endtask

    task automatic xfer_chk(input string name, input int d, input logic w, input logic [5:0] a,
                            input logic [31:0] wd, input logic [3:0] s, input logic [31:0] exp_rd,
                            input logic exp_err, input int exp_wait);
        logic [31:0] rd;
        logic err, tmo;
        int nw;
        xfer(d, w, a, wd, s, rd, err, nw, tmo);
        chk({name, " timeout"}, {31'b0, tmo}, 32'd0);
        chk({name, " rdata"}, rd, exp_rd);
        chk({name, " slverr"}, {31'b0, err}, {31'b0, exp_err});
        chk({name, " wait"}, nw, exp_wait);
    endtask

    initial begin
        vt[0]  = '{0, 1'b0, 6'd5,  32'h0,        4'h0, 32'hA5A5A5A5, 1'b0, 0};
        vt[1]  = '{0, 1'b0, 6'd47, 32'h0,        4'h0, 32'hA5A5A5A5, 1'b0, 0};
        vt[2]  = '{0, 1'b1, 6'd50, 32'hDEADBEEF, 4'hF, 32'h0,        1'b1, 0};
        vt[3]  = '{0, 1'b0, 6'd50, 32'h0,        4'h0, 32'h0,        1'b1, 0};
        vt[4]  = '{0, 1'b0, 6'd2,  32'h0,        4'h0, 32'hA5A5A5A5, 1'b0, 0};
        vt[5]  = '{3, 1'b1, 6'd3,  32'h11223344, 4'h5, 32'h0,        1'b0, 3};
        vt[6]  = '{3, 1'b0, 6'd3,  32'h0,        4'h0, 32'h00220044, 1'b0, 3};
        vt[7]  = '{3, 1'b0, 6'd2,  32'h0,        4'h0, 32'h0,        1'b0, 3};
        vt[8]  = '{3, 1'b1, 6'd7,  32'hFFFFFFFF, 4'h0, 32'h0,        1'b0, 3};
        vt[9]  = '{3, 1'b0, 6'd7,  32'h0,        4'h0, 32'h0,        1'b0, 3};
        vt[10] = '{3, 1'b1, 6'd7,  32'h12345678, 4'hF, 32'h0,        1'b0, 3};
        vt[11] = '{3, 1'b0, 6'd7,  32'h0,        4'h0, 32'h12345678, 1'b0, 3};
        vt[12] = '{3, 1'b1, 6'd7,  32'hAB000000, 4'h8, 32'h0,        1'b0, 3};
        vt[13] = '{3, 1'b0, 6'd7,  32'h0,        4'h0, 32'hAB345678, 1'b0, 3};
        vt[14] = '{3, 1'b1, 6'd63, 32'hFFFFFFFF, 4'hF, 32'h0,        1'b1, 3};
        vt[15] = '{3, 1'b0, 6'd63, 32'h0,        4'h0, 32'h0,        1'b1, 3};

        #1;
        chk("reset ready", {31'b0, ready0}, 32'd0);
        chk("reset rdata", rdata0, 32'd0);
        chk("reset slverr", {31'b0, slverr0}, 32'd0);
        chk("reset ready3", {31'b0, ready3}, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 16; i++)
            xfer_chk($sformatf("vec%0d", i), vt[i].d, vt[i].w, vt[i].a, vt[i].wd, vt[i].s,
                     vt[i].exp_rd, vt[i].exp_err, vt[i].exp_wait);
        xfer_chk("reg3 intact", 3, 1'b0, 6'd3, 32'h0, 4'h0, 32'h00220044, 1'b0, 3);

        // Protocol violation: sel and enable together from IDLE are ignored.
        @(negedge clk);
        sel0 = 1'b1; enable = 1'b1; wr = 1'b0; addr = 6'd5;
        @(negedge clk);
        chk("violation ready", {31'b0, ready0}, 32'd0);
        sel0 = 1'b0; enable = 1'b0;

        // Back-to-back: second setup in the cycle right after completion.
        @(negedge clk);
        sel0 = 1'b1; enable = 1'b0; wr = 1'b0; addr = 6'd5;
        @(negedge clk);
        enable = 1'b1;
        chk("b2b first ready", {31'b0, ready0}, 32'd1);
        @(negedge clk);
        chk("b2b idle ready", {31'b0, ready0}, 32'd0);
        enable = 1'b0; addr = 6'd47;
        @(negedge clk);
        enable = 1'b1;
        chk("b2b second ready", {31'b0, ready0}, 32'd1);
        chk("b2b second rdata", rdata0, 32'hA5A5A5A5);
        @(negedge clk);
        sel0 = 1'b0; enable = 1'b0;

        // Abort during wait states: sel dropped in the 2nd access cycle.
        @(negedge clk);
        sel3 = 1'b1; enable = 1'b0; wr = 1'b1; addr = 6'd1; wdata = 32'hFFFFFFFF; strb = 4'hF;
        @(negedge clk);
        enable = 1'b1;
        chk("abort access1 ready", {31'b0, ready3}, 32'd0);
        @(negedge clk);
        sel3 = 1'b0; enable = 1'b0;
        xfer_chk("abort wait addr1", 3, 1'b0, 6'd1, 32'h0, 4'h0, 32'h0, 1'b0, 3);

        // Abort from READY on the zero-wait instance.
        @(negedge clk);
        sel0 = 1'b1; enable = 1'b0; wr = 1'b1; addr = 6'd4; wdata = 32'h0; strb = 4'hF;
        @(negedge clk);
        chk("abort ready phase", {31'b0, ready0}, 32'd1);
        sel0 = 1'b0;
        xfer_chk("abort ready addr4", 0, 1'b0, 6'd4, 32'h0, 4'h0, 32'hA5A5A5A5, 1'b0, 0);

`ifdef APB_REG_BANK_LOCK_EN
        xfer_chk("lock set", 3, 1'b1, 6'd47, 32'h1, 4'hF, 32'h0, 1'b0, 3);
        xfer_chk("locked write", 3, 1'b1, 6'd0, 32'hCAFEF00D, 4'hF, 32'h0, 1'b1, 3);
        xfer_chk("locked read", 3, 1'b0, 6'd0, 32'h0, 4'h0, 32'h0, 1'b0, 3);
        xfer_chk("lock clear", 3, 1'b1, 6'd47, 32'h0, 4'hF, 32'h0, 1'b0, 3);
        xfer_chk("unlocked write", 3, 1'b1, 6'd0, 32'hCAFEF00D, 4'hF, 32'h0, 1'b0, 3);
        xfer_chk("unlocked read", 3, 1'b0, 6'd0, 32'h0, 4'h0, 32'hCAFEF00D, 1'b0, 3);
`else
        xfer_chk("last reg write", 3, 1'b1, 6'd47, 32'h1, 4'hF, 32'h0, 1'b0, 3);
        xfer_chk("last reg read", 3, 1'b0, 6'd47, 32'h0, 4'h0, 32'h1, 1'b0, 3);
        xfer_chk("addr0 write", 3, 1'b1, 6'd0, 32'hCAFEF00D, 4'hF, 32'h0, 1'b0, 3);
        xfer_chk("addr0 read", 3, 1'b0, 6'd0, 32'h0, 4'h0, 32'hCAFEF00D, 1'b0, 3);
`endif

        // Reset in the middle of a read access: outputs clear immediately.
        @(negedge clk);
        sel0 = 1'b1; enable = 1'b0; wr = 1'b0; addr = 6'd5;
        @(negedge clk);
        enable = 1'b1;
        chk("pre-reset ready", {31'b0, ready0}, 32'd1);
        #1 reset = 1'b1;
        #1;
        chk("mid reset ready", {31'b0, ready0}, 32'd0);
        chk("mid reset rdata", rdata0, 32'd0);
        @(negedge clk);
        sel0 = 1'b0; enable = 1'b0; reset = 1'b0;
        xfer_chk("post reset reg3", 3, 1'b0, 6'd3, 32'h0, 4'h0, 32'h0, 1'b0, 3);
        xfer_chk("post reset reg7", 3, 1'b0, 6'd7, 32'h0, 4'h0, 32'h0, 1'b0, 3);
        xfer_chk("post reset reg0", 3, 1'b0, 6'd0, 32'h0, 4'h0, 32'h0, 1'b0, 3);

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end
endmodule
